// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a shared stack: one push/pop in flight,
// alternating priority when both requesters contend.
module stack_arbiter #(
    parameter int unsigned B = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         op0,
    input  logic         op1,
    input  logic [B-1:0] wdata0,
    input  logic [B-1:0] wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic         err,
    output logic         rvalid,
    output logic [B-1:0] rdata,
    output logic         busy,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [B-1:0] stk_push_data,
    input  logic [B-1:0] stk_pop_data,
    input  logic         stk_full,
    input  logic         stk_empty
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]   state,       state_d;
    logic         win,         win_d;
    logic         op_q,        op_d;
    logic [B-1:0] wdata_q,     wdata_d;
    logic         prio,        prio_d;
    logic         err_flag,    err_flag_d;
    logic         rvalid_flag, rvalid_flag_d;
    logic [B-1:0] rdata_d;

    // Push data is the word latched at grant time; it is stable through ISSUE.
    assign stk_push_data = wdata_q;

    // Next-state, latch and strobe logic; stack flags only matter in ISSUE.
    always_comb begin
        state_d       = state;
        win_d         = win;
        op_d          = op_q;
        wdata_d       = wdata_q;
        prio_d        = prio;
        err_flag_d    = err_flag;
        rvalid_flag_d = rvalid_flag;
        rdata_d       = rdata;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win_d         = req1 && (!req0 || prio);
                    op_d          = win_d ? op1 : op0;
                    wdata_d       = win_d ? wdata1 : wdata0;
                    err_flag_d    = 1'b0;
                    rvalid_flag_d = 1'b0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (op_q) begin
                    if (!stk_full) begin
                        stk_push = 1'b1;
                    end else begin
                        err_flag_d = 1'b1;
                    end
                    state_d = DONE;
                end else if (!stk_empty) begin
                    stk_pop = 1'b1;
                    state_d = WAIT_RD;
                end else begin
                    err_flag_d = 1'b1;
                    state_d    = DONE;
                end
            end
            WAIT_RD: begin
                rdata_d       = stk_pop_data;
                rvalid_flag_d = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                prio_d  = !win;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; ack/err/rvalid assert only while in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            win         <= 1'b0;
            op_q        <= 1'b0;
            wdata_q     <= '0;
            prio        <= 1'b0;
            err_flag    <= 1'b0;
            rvalid_flag <= 1'b0;
            rdata       <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err         <= 1'b0;
            rvalid      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            win         <= win_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            prio        <= prio_d;
            err_flag    <= err_flag_d;
            rvalid_flag <= rvalid_flag_d;
            rdata       <= rdata_d;
            ack0        <= (state_d == DONE) && !win_d;
            ack1        <= (state_d == DONE) && win_d;
            err         <= (state_d == DONE) && err_flag_d;
            rvalid      <= (state_d == DONE) && rvalid_flag_d;
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a behavioural 16-entry stack model.
module tb_stack_arbiter;

    typedef struct packed {
        logic       who;
        logic       err;
        logic       rvalid;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, op0, op1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, err, rvalid, busy, stk_push, stk_pop;
    logic [7:0] rdata, stk_push_data, stk_pop_data;
    logic       stk_full, stk_empty;

    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;

    int         sp = 0;
    logic [7:0] mem [16];
    logic [7:0] pop_q = 8'h00;
    logic       clr_stk = 1'b1;
    logic       force_full = 1'b0;

    stack_arbiter #(.B(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rvalid(rvalid), .rdata(rdata),
        .busy(busy), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_push_data(stk_push_data), .stk_pop_data(stk_pop_data),
        .stk_full(stk_full), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Stack model: read data valid the cycle after the pop strobe.
    assign stk_full     = (sp == 16) || force_full;
    assign stk_empty    = (sp == 0);
    assign stk_pop_data = pop_q;

    always @(posedge clk) begin
        if (clr_stk) begin
            sp <= 0;
        end else if (stk_push && sp < 16) begin
            mem[sp] <= stk_push_data;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            pop_q <= mem[sp-1];
            sp    <= sp - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack is matched against the oldest expectation.
    always @(negedge clk) begin
        check("strobe_excl", 32'(stk_push & stk_pop), 0);
        if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_who", 32'(ack1), 32'(mon_e.who));
                check("ack_both", 32'(ack0 & ack1), 0);
                check("err", 32'(err), 32'(mon_e.err));
                check("rvalid", 32'(rvalid), 32'(mon_e.rvalid));
                if (mon_e.rvalid) check("rdata", 32'(rdata), 32'(mon_e.rdata));
            end
        end else begin
            check("flags_no_ack", 32'(err | rvalid), 0);
        end
    end

    task automatic apply_reset(input bit clear_stack);
        reset = 1'b1;
        clr_stk = clear_stack;
        @(negedge clk);
        @(negedge clk);
        check("rst_acks", 32'({ack0, ack1, err, rvalid}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", 32'({stk_push, stk_pop}), 0);
        check("rst_rdata", 32'(rdata), 0);
        reset = 1'b0;
        clr_stk = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input bit who, input bit op, input logic [7:0] data,
                         input bit exp_err, input logic [7:0] exp_rd);
        exp_t e;
        int   k;
        bit   got;
        bit   rd;
        int   lat;
        rd       = !op && !exp_err;
        lat      = rd ? 3 : 2;
        e.who    = who;
        e.err    = exp_err;
        e.rvalid = rd;
        e.rdata  = exp_rd;
        exp_q.push_back(e);
        if (who) begin req1 = 1'b1; op1 = op; wdata1 = data; end
        else     begin req0 = 1'b1; op0 = op; wdata0 = data; end
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("push_strobe", 32'(stk_push), 32'(op && !exp_err));
                check("pop_strobe", 32'(stk_pop), 32'(!op && !exp_err));
                if (op && !exp_err) check("push_data", 32'(stk_push_data), 32'(data));
            end
            got = who ? ack1 : ack0;
        end
        check("ack_latency", got ? k : 99, lat);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = 0; wdata1 = 0;
        apply_reset(1'b1);

        // Single push, then pop of a known top word, then pop underneath.
        do_op(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
        do_op(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        do_op(1'b1, 1'b0, 8'h00, 1'b0, 8'h3C);
        do_op(1'b0, 1'b0, 8'h00, 1'b0, 8'hA5);

        // Rejections: pop on empty, push on full.
        do_op(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        force_full = 1'b1;
        do_op(1'b1, 1'b1, 8'h77, 1'b1, 8'h00);
        force_full = 1'b0;

        // Contention after reset: grants alternate 0,1,0,1.
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{who: 1'(i % 2), err: 1'b0, rvalid: 1'b0, rdata: 8'h00});
        end
        req0 = 1; op0 = 1; wdata0 = 8'h11;
        req1 = 1; op1 = 1; wdata1 = 8'h22;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
        end
        req0 = 0; req1 = 0;
        check("alt_acks", n, 4);
        @(negedge clk);
        @(negedge clk);

        // Stack now 11,22,11,22 (top last); pop leaves rdata non-zero.
        do_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h22);

        // Reset while waiting for read data aborts the pop silently.
        req1 = 1; op1 = 0;
        @(negedge clk);
        check("abort_pop_strobe", 32'(stk_pop), 1);
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_rdata", 32'(rdata), 0);
        check("abort_acks", 32'({ack0, ack1}), 0);
        reset = 1'b0;
        req1 = 0;
        repeat (4) @(negedge clk);
        check("abort_idle", 32'(busy), 0);
        do_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h22);

        // Fill to sixteen, overflow once, then drain in LIFO order.
        apply_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            do_op(1'(i % 2), 1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
        end
        do_op(1'b0, 1'b1, 8'hEE, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            do_op(1'(i % 2), 1'b0, 8'h00, 1'b0, 8'(8'h4F - i));
        end
        do_op(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
